ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the attached keyboard using the PS/2 host request protocol. It sits beside the existing PS/2 receiver on the same `ps2_clk`/`ps2_data` lines and drives them open-drain via output-enable pins. It reports device acknowledge, no-acknowledge or timeout. The device's 0xFA reply byte is received by the existing receiver path, not by this block.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, error codes and the
// keyboard command bytes used by the host side.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_PRE,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NACK     = 2'd1;
    localparam logic [1:0] ERR_START_TO = 2'd2;
    localparam logic [1:0] ERR_BIT_TO   = 2'd3;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // PS/2 uses odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus falling-edge detect on the
// synchronized level. Reset parks the chain at the idle-high bus level.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_pad,
    output logic o_level,
    output logic o_fe
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_fe    = r_s3 & ~r_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues a request
// to send, shifts out data/parity/stop on device clock edges and checks the ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int START_TO_US = 15000,
    parameter int BIT_TO_US   = 2000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    // Divide first so START_TO at 100 MHz stays well inside 32-bit math.
    localparam int CYC_PER_US   = CLK_FREQ_HZ / 1_000_000;
    localparam int INHIBIT_CYC  = CYC_PER_US * INHIBIT_US;
    localparam int START_TO_CYC = CYC_PER_US * START_TO_US;
    localparam int BIT_TO_CYC   = CYC_PER_US * BIT_TO_US;
    localparam int TMR_MAX_A    = (INHIBIT_CYC > BIT_TO_CYC) ? INHIBIT_CYC : BIT_TO_CYC;
    localparam int TMR_MAX      = (TMR_MAX_A > START_TO_CYC) ? TMR_MAX_A : START_TO_CYC;
    localparam int TMR_W        = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INHIBIT_LD  = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] START_TO_LD = TMR_W'(START_TO_CYC - 1);
    localparam logic [TMR_W-1:0] BIT_TO_LD   = TMR_W'(BIT_TO_CYC - 1);

    logic w_clk_lvl;
    logic w_clk_fe;
    logic w_data_lvl;
    logic w_data_fe_unused;
    logic w_tmr_zero;
    logic w_bus_idle;

    ps2_tx_state_t    r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [9:0]       r_frame;
    logic [3:0]       r_bit;
    logic             r_nack;
    logic             r_tx_ready;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;

    ps2_line_sync u_sync_clk (
        .i_clk   (clk),
        .i_clr   (clr),
        .i_pad   (ps2_clk),
        .o_level (w_clk_lvl),
        .o_fe    (w_clk_fe)
    );

    ps2_line_sync u_sync_data (
        .i_clk   (clk),
        .i_clr   (clr),
        .i_pad   (ps2_data),
        .o_level (w_data_lvl),
        .o_fe    (w_data_fe_unused)
    );

    assign w_tmr_zero = (r_tmr == '0);
    assign w_bus_idle = w_clk_lvl & w_data_lvl;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_frame    <= '1;
            r_bit      <= '0;
            r_nack     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && r_tx_ready) begin
                        // Frame shifts out LSB first; the top 1 becomes the stop bit.
                        r_frame    <= {1'b1, odd_parity(tx_data), tx_data};
                        r_bit      <= '0;
                        r_nack     <= 1'b0;
                        r_tmr      <= INHIBIT_LD;
                        r_err_code <= ERR_NONE;
                        r_tx_ready <= 1'b0;
                        r_clk_oe   <= 1'b1;
                        r_data_oe  <= 1'b0;
                        r_state    <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (w_tmr_zero) begin
                        r_data_oe <= 1'b1;
                        r_state   <= ST_PRE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end

                ST_PRE: begin
                    r_clk_oe <= 1'b0;
                    r_tmr    <= START_TO_LD;
                    r_state  <= ST_REQ;
                end

                ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
                    if (r_state == ST_WAIT_IDLE && w_bus_idle) begin
                        r_tx_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                        if (r_nack) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_NACK;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else if (w_clk_fe) begin
                        // An edge always beats a simultaneous watchdog expiry.
                        r_tmr <= BIT_TO_LD;
                        if (r_state == ST_REQ || r_state == ST_SHIFT) begin
                            r_data_oe <= ~r_frame[0];
                            r_frame   <= {1'b1, r_frame[9:1]};
                            r_bit     <= r_bit + 4'd1;
                            if (r_state == ST_REQ)
                                r_state <= ST_SHIFT;
                            else if (r_bit == 4'd9)
                                r_state <= ST_ACK;
                        end else if (r_state == ST_ACK) begin
                            r_nack  <= w_data_lvl;
                            r_state <= ST_WAIT_IDLE;
                        end
                    end else if (w_tmr_zero) begin
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= (r_state == ST_REQ) ? ERR_START_TO : ERR_BIT_TO;
                        r_tx_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end

                default: begin
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = r_tx_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model on open-drain lines clocks
// frames in, acks or nacks, stalls, and the host is reset mid-frame.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    // 1 MHz system clock: one cycle per microsecond.
    localparam int I_CYC = 20;
    localparam int S_CYC = 200;
    localparam int B_CYC = 60;
    localparam int HI    = 6;
    localparam int LO    = 6;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pad;
    logic       ps2_data_pad;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int pulse_cyc = 0;
    logic pulse_rdy = 1'b0;

    assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (20),
        .START_TO_US (200),
        .BIT_TO_US   (60)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk     (ps2_clk_pad),
        .ps2_data    (ps2_data_pad),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt  <= done_cnt + 1;
            pulse_cyc <= cyc;
            pulse_rdy <= tx_ready;
        end
        if (err) begin
            err_cnt   <= err_cnt + 1;
            pulse_cyc <= cyc;
            pulse_rdy <= tx_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, output int acc);
        for (int k = 0; k < 50 && !tx_ready; k++) tick();
        tx_data  = d;
        tx_valid = 1'b1;
        acc      = cyc;
        tick();
        tx_valid = 1'b0;
        chk("acc_ready", tx_ready, 1'b0);
        chk("acc_clk_oe", ps2_clk_oe, 1'b1);
    endtask

    // Keyboard model: waits for the request, then generates nclk clock pulses,
    // capturing the data line while the clock is low.
    task automatic dev_run(input int nclk, input bit do_ack, input int clr_at,
                           output logic [9:0] seen, output int req_c,
                           output int lat1, output int fall_c);
        seen   = '0;
        req_c  = -1;
        lat1   = -1;
        fall_c = 0;
        for (int w = 0; w < I_CYC + 10; w++) begin
            if (!ps2_clk_oe && ps2_data_oe) begin
                req_c = cyc;
                break;
            end
            tick();
        end
        if (req_c < 0) begin
            chk("req_seen", 1'b0, 1'b1);
            return;
        end
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11) dev_data_low = do_ack;
            repeat (HI) tick();
            dev_clk_low = 1'b1;
            fall_c = cyc;
            for (int j = 0; j < LO; j++) begin
                tick();
                if (k == 1 && lat1 < 0 && !ps2_data_oe) lat1 = cyc - fall_c;
            end
            if (k <= 10) seen[k-1] = ps2_data_pad;
            if (k == clr_at) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                dev_clk_low = 1'b0;
                return;
            end
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_pulse(input int base, input int bound);
        for (int i = 0; i < bound && (done_cnt + err_cnt) == base; i++) tick();
        if ((done_cnt + err_cnt) == base) chk("pulse_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int acc, req_c, lat1, fall_c, b_done, b_err;
        logic [9:0] seen;

        repeat (3) tick();
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        chk("rst_pulses", {done, err}, 2'b00);
        chk("rst_code", err_code, 2'd0);
        clr = 1'b0;
        tick();

        // Set-LEDs command with ack
        b_done = done_cnt; b_err = err_cnt;
        send(CMD_SET_LED, acc);
        dev_run(11, 1'b1, 0, seen, req_c, lat1, fall_c);
        chk("ed_inhibit_len", req_c - acc, I_CYC + 2);
        chk("ed_bit0_latency", lat1, 3);
        chk("ed_bits", seen, 10'h3ED);
        wait_pulse(b_done + b_err, 40);
        chk("ed_done", done_cnt - b_done, 1);
        chk("ed_no_err", err_cnt - b_err, 0);
        chk("ed_code", err_code, 2'd0);
        chk("ed_ready_at_pulse", pulse_rdy, 1'b1);

        // Parity extremes
        b_done = done_cnt; b_err = err_cnt;
        send(8'h00, acc);
        dev_run(11, 1'b1, 0, seen, req_c, lat1, fall_c);
        chk("p00_bits", seen, 10'h300);
        wait_pulse(b_done + b_err, 40);
        chk("p00_done", done_cnt - b_done, 1);

        b_done = done_cnt; b_err = err_cnt;
        send(8'h01, acc);
        dev_run(11, 1'b1, 0, seen, req_c, lat1, fall_c);
        chk("p01_bits", seen, 10'h201);
        wait_pulse(b_done + b_err, 40);
        chk("p01_done", done_cnt - b_done, 1);

        // Device leaves data high at clock 11
        b_done = done_cnt; b_err = err_cnt;
        send(8'hA5, acc);
        dev_run(11, 1'b0, 0, seen, req_c, lat1, fall_c);
        chk("nack_bits", seen, 10'h3A5);
        wait_pulse(b_done + b_err, 40);
        chk("nack_err", err_cnt - b_err, 1);
        chk("nack_no_done", done_cnt - b_done, 0);
        chk("nack_code", err_code, 2'd1);
        chk("nack_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // Device never clocks
        b_done = done_cnt; b_err = err_cnt;
        send(8'h3C, acc);
        dev_run(0, 1'b0, 0, seen, req_c, lat1, fall_c);
        wait_pulse(b_done + b_err, S_CYC + 30);
        chk("sto_err", err_cnt - b_err, 1);
        chk("sto_code", err_code, 2'd2);
        chk("sto_delay", pulse_cyc - req_c, S_CYC);
        chk("sto_ready_at_pulse", pulse_rdy, 1'b1);
        chk("sto_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // Device stalls after five clocks
        b_done = done_cnt; b_err = err_cnt;
        send(8'h55, acc);
        dev_run(5, 1'b0, 0, seen, req_c, lat1, fall_c);
        wait_pulse(b_done + b_err, B_CYC + 30);
        chk("bto_err", err_cnt - b_err, 1);
        chk("bto_code", err_code, 2'd3);
        chk("bto_delay", pulse_cyc - fall_c, B_CYC + 3);
        chk("bto_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        // Reset while bit 4 is on the wire, then a clean reset command
        b_done = done_cnt; b_err = err_cnt;
        send(8'h12, acc);
        dev_run(11, 1'b1, 4, seen, req_c, lat1, fall_c);
        chk("clr_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("clr_ready", tx_ready, 1'b1);
        chk("clr_code", err_code, 2'd0);
        repeat (10) tick();
        chk("clr_no_pulse", (done_cnt - b_done) + (err_cnt - b_err), 0);

        b_done = done_cnt; b_err = err_cnt;
        send(CMD_RESET, acc);
        dev_run(11, 1'b1, 0, seen, req_c, lat1, fall_c);
        chk("ff_bits", seen, 10'h3FF);
        wait_pulse(b_done + b_err, 40);
        chk("ff_done", done_cnt - b_done, 1);
        chk("ff_code", err_code, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
